// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one 1-bit full adder time-shared over WIDTH cycles, LSB first.

module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  // Plain combinational full adder
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_addsub_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a, sh_b, sh_r;
  logic [CW-1:0]    bit_cnt;
  logic             carry;
  logic             load_c, step_c, last_c;
  logic             busy_d, done_d;
  logic             fa_sum, fa_cout;

  assign last_c = (bit_cnt == CW'(WIDTH - 1));

  // The single shared adder sees the current LSBs and the carry flop
  full_adder_1bit u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, datapath strobes and next values of the registered status outputs
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (last_c) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Registered handshake outputs track the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  // Operand shifters, carry flop, bit counter and the result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a    <= '0;
      sh_b    <= '0;
      sh_r    <= '0;
      bit_cnt <= '0;
      carry   <= 1'b0;
      Result  <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
    end else if (load_c) begin
      sh_a    <= A;
      sh_b    <= op_sub ? ~B : B;
      carry   <= op_sub;
      bit_cnt <= '0;
    end else if (step_c) begin
      sh_a    <= sh_a >> 1;
      sh_b    <= sh_b >> 1;
      sh_r    <= {fa_sum, sh_r[WIDTH-1:1]};
      carry   <= fa_cout;
      bit_cnt <= bit_cnt + CW'(1);
      if (last_c) begin
        // carry flop still holds the carry into the MSB on this edge
        Result <= {fa_sum, sh_r[WIDTH-1:1]};
        Cout   <= fa_cout;
        Ovf    <= carry ^ fa_cout;
      end
    end
  end

endmodule
